// File: rtl/uart_pkg.sv
// Shared UART definitions: serialiser states, frame-format encodings
// and a data-width mask helper used by the TX path (and later RX).
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;

  // data_bits encodings
  localparam logic [1:0] DB5 = 2'd0;
  localparam logic [1:0] DB6 = 2'd1;
  localparam logic [1:0] DB7 = 2'd2;
  localparam logic [1:0] DB8 = 2'd3;

  // parity_odd encodings
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Mask selecting the bits that go on the wire for a data width.
  function automatic logic [7:0] data_mask(
    input logic [1:0] db
  );
    logic [7:0] m;
    m = 8'hFF;
    unique case (db)
      DB5:     m = 8'h1F;
      DB6:     m = 8'h3F;
      DB7:     m = 8'h7F;
      DB8:     m = 8'hFF;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

  // Index of the last data bit for a data width (5..8 bits).
  function automatic logic [2:0] last_bit(
    input logic [1:0] db
  );
    return {1'b0, db} + 3'd4;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with first-word fall-through read.
// Ports: push_i/wdata_i, pop_i/rdata_o, full_o, empty_o, level_o.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [LW-1:0]    level_q;
  logic [LW-1:0]    level_d;
  logic             full_q;
  logic             empty_q;
  logic             do_push;
  logic             do_pop;

  assign do_push = push_i && !full_q;
  assign do_pop  = pop_i && !empty_q;

  always_comb begin
    level_d = level_q;
    unique case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Flags are registered from the next level so they are
  // valid the cycle after any push or pop.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (do_push) begin
        wptr_q <= wptr_q + 1'b1;
      end
      if (do_pop) begin
        rptr_q <= rptr_q + 1'b1;
      end
      level_q <= level_d;
      full_q  <= (level_d == LW'(DEPTH));
      empty_q <= (level_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign level_o = level_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a TX FIFO, runtime 5-8 data bits,
// optional parity, 1/2 stop bits, div clk cycles per symbol.
// Ports: valid/tx_data/ready push side; div, data_bits,
// parity_en, parity_odd, stop2 format; tx_out, busy, tx_done,
// level status.
import uart_pkg::*;

module uart_tx_fifo #(
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         valid,
  input  logic [7:0]                   tx_data,
  output logic                         ready,
  input  logic [DIV_W-1:0]             div,
  input  logic [1:0]                   data_bits,
  input  logic                         parity_en,
  input  logic                         parity_odd,
  input  logic                         stop2,
  output logic                         tx_out,
  output logic                         busy,
  output logic                         tx_done,
  output logic [$clog2(FIFO_DEPTH):0]  level
);

  localparam int TW = DIV_W + 1;

  logic [7:0]       fifo_rdata;
  logic             fifo_full;
  logic             fifo_empty;
  logic             load;

  uart_state_e      state_q;
  logic [7:0]       shreg_q;
  logic [2:0]       bit_q;
  logic [2:0]       last_q;
  logic             par_en_q;
  logic             par_q;
  logic             stop2_q;
  logic [DIV_W-1:0] div_q;
  logic [TW-1:0]    tmr_q;
  logic             tx_q;
  logic             done_q;

  logic [DIV_W-1:0] div_eff;
  logic [7:0]       ld_byte;
  logic [TW-1:0]    ld_m1;
  logic [TW-1:0]    sym_m1;
  logic [TW-1:0]    stop_m1;
  logic             tmr_zero;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push_i  (valid),
    .wdata_i (tx_data),
    .pop_i   (load),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level)
  );

  assign ready = !fifo_full;

  assign div_eff = (div == '0) ? DIV_W'(1) : div;
  assign ld_byte = fifo_rdata & data_mask(data_bits);
  assign ld_m1   = {1'b0, div_eff} - TW'(1);
  assign sym_m1  = {1'b0, div_q} - TW'(1);
  // Two stop bits run as one symbol of twice the length.
  assign stop_m1 = stop2_q ? ({div_q, 1'b0} - TW'(1))
                           : sym_m1;
  assign tmr_zero = (tmr_q == '0);

  // A new frame starts from IDLE or straight out of the
  // final stop cycle, so back-to-back frames have no gap.
  assign load = !fifo_empty &&
                ((state_q == ST_IDLE) ||
                 ((state_q == ST_STOP) && tmr_zero));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      shreg_q  <= '0;
      bit_q    <= '0;
      last_q   <= '0;
      par_en_q <= 1'b0;
      par_q    <= 1'b0;
      stop2_q  <= 1'b0;
      div_q    <= DIV_W'(1);
      tmr_q    <= '0;
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (load) begin
        state_q  <= ST_START;
        tx_q     <= 1'b0;
        shreg_q  <= ld_byte;
        bit_q    <= '0;
        last_q   <= last_bit(data_bits);
        par_en_q <= parity_en;
        // Masked byte, so only transmitted bits count.
        par_q    <= (^ld_byte) ^ parity_odd;
        stop2_q  <= stop2;
        div_q    <= div_eff;
        tmr_q    <= ld_m1;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            tx_q <= 1'b1;
          end
          ST_START: begin
            if (tmr_zero) begin
              state_q <= ST_DATA;
              bit_q   <= '0;
              tx_q    <= shreg_q[0];
              shreg_q <= shreg_q >> 1;
              tmr_q   <= sym_m1;
            end else begin
              tmr_q <= tmr_q - 1'b1;
            end
          end
          ST_DATA: begin
            if (!tmr_zero) begin
              tmr_q <= tmr_q - 1'b1;
            end else if (bit_q != last_q) begin
              bit_q   <= bit_q + 1'b1;
              tx_q    <= shreg_q[0];
              shreg_q <= shreg_q >> 1;
              tmr_q   <= sym_m1;
            end else if (par_en_q) begin
              state_q <= ST_PARITY;
              tx_q    <= par_q;
              tmr_q   <= sym_m1;
            end else begin
              state_q <= ST_STOP;
              tx_q    <= 1'b1;
              tmr_q   <= stop_m1;
              done_q  <= (stop_m1 == '0);
            end
          end
          ST_PARITY: begin
            if (tmr_zero) begin
              state_q <= ST_STOP;
              tx_q    <= 1'b1;
              tmr_q   <= stop_m1;
              done_q  <= (stop_m1 == '0);
            end else begin
              tmr_q <= tmr_q - 1'b1;
            end
          end
          ST_STOP: begin
            if (tmr_zero) begin
              state_q <= ST_IDLE;
              tx_q    <= 1'b1;
            end else begin
              tmr_q  <= tmr_q - 1'b1;
              // High during the final stop cycle.
              done_q <= (tmr_q == TW'(1));
            end
          end
          default: begin
            state_q <= ST_IDLE;
            tx_q    <= 1'b1;
          end
        endcase
      end
    end
  end

  assign tx_out  = tx_q;
  assign tx_done = done_q;
  assign busy    = (state_q != ST_IDLE) || !fifo_empty;

endmodule
